// File: rtl/vga_board_renderer_pkg.sv
// vga_pkg: shared colours, owner codes, region classes and default 640x480
// timing for the board display blocks.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam logic [11:0] COL_BLANK  = 12'h000;
  localparam logic [11:0] COL_GRID   = 12'hCCC;
  localparam logic [11:0] COL_EMPTY  = 12'hDDD;
  localparam logic [11:0] COL_P1     = 12'hF70;
  localparam logic [11:0] COL_P2     = 12'h70F;
  localparam logic [11:0] COL_P3     = 12'h0A0;
  localparam logic [11:0] COL_P4     = 12'hD00;
  localparam logic [11:0] COL_LEFT   = 12'h222;
  localparam logic [11:0] COL_RIGHT  = 12'h444;
  localparam logic [11:0] COL_OUTER  = 12'hEEE;
  localparam logic [11:0] COL_CURSOR = 12'h000;

  typedef enum logic [2:0] {
    OWNER_EMPTY = 3'd0,
    OWNER_P1    = 3'd1,
    OWNER_P2    = 3'd2,
    OWNER_P3    = 3'd3,
    OWNER_P4    = 3'd4
  } owner_e;

  typedef enum logic [2:0] {
    REG_BLANK,
    REG_GRID,
    REG_CELL,
    REG_LEFT,
    REG_RIGHT,
    REG_OUTER
  } region_e;

  // Codes 5..7 are reserved and render as an empty cell.
  function automatic logic [11:0] owner_colour(input logic [2:0] code);
    logic [11:0] c;
    case (code)
      OWNER_P1: c = COL_P1;
      OWNER_P2: c = COL_P2;
      OWNER_P3: c = COL_P3;
      OWNER_P4: c = COL_P4;
      default:  c = COL_EMPTY;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_board_renderer_if.sv
// Board VRAM read port: registered address out, data back one cycle later.
interface vga_board_renderer_if #(
  parameter int ADDR_W    = 8,
  parameter int CELL_BITS = 6
);
  logic [ADDR_W-1:0]    vram_addr;
  logic [CELL_BITS-1:0] vram_q;

  modport master (output vram_addr, input vram_q);
  modport slave  (input vram_addr, output vram_q);
endinterface

// File: rtl/vga_board_renderer_timing.sv
// vga_timing: free-running raster counters with visible flag and raw
// active-low syncs, shared by the display blocks.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW       = $clog2(H_TOTAL),
  localparam int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          h_wrap,
  output logic          v_wrap,
  output logic          visible,
  output logic          hsync_raw,
  output logic          vsync_raw
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_wrap) begin
      hcount <= '0;
      vcount <= v_wrap ? '0 : vcount + 1'b1;
    end else begin
      hcount <= hcount + 1'b1;
    end
  end

  assign h_wrap    = (hcount == HW'(H_TOTAL - 1));
  assign v_wrap    = (vcount == VW'(V_TOTAL - 1));
  assign visible   = (int'(hcount) < H_VISIBLE) && (int'(vcount) < V_VISIBLE);
  assign hsync_raw = !((int'(hcount) >= H_VISIBLE + H_FRONT) &&
                       (int'(hcount) <  H_VISIBLE + H_FRONT + H_SYNC));
  assign vsync_raw = !((int'(vcount) >= V_VISIBLE + V_FRONT) &&
                       (int'(vcount) <  V_VISIBLE + V_FRONT + V_SYNC));

endmodule

// File: rtl/vga_board_renderer.sv
// Board renderer: tiles VRAM cells onto the raster through a 3-stage pipeline.
// Optional blinking cell cursor is built when VGA_CURSOR_EN is defined.
module vga_board_renderer
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int BOARD_W   = 14,
  parameter int BOARD_H   = 14,
  parameter int CELL      = 32,
  parameter int GRID      = 2,
  parameter int ORG_X     = 95,
  parameter int ORG_Y     = 15,
  parameter int CELL_BITS = 6,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  vga_board_renderer_if.master vram,
`ifdef VGA_CURSOR_EN
  input  logic [3:0]           cursor_x,
  input  logic [3:0]           cursor_y,
`endif
  output logic                 hsync,
  output logic                 vsync,
  output logic [11:0]          rgb_out,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = $clog2(CELL);
  localparam int CXW     = $clog2(BOARD_W + 1);
  localparam int CYW     = $clog2(BOARD_H + 1);
  localparam int X_END   = ORG_X + BOARD_W * CELL + GRID;
  localparam int Y_END   = ORG_Y + BOARD_H * CELL + GRID;

  logic [HW-1:0]     hcount, h_next;
  logic [VW-1:0]     vcount, v_next;
  logic              h_wrap, v_wrap, visible, hsync_raw, vsync_raw;
  logic [PW-1:0]     px_x, px_y;
  logic [CXW-1:0]    cell_x;
  logic [CYW-1:0]    cell_y;
  logic              in_board_x, in_board_y, on_grid, fs_s0;
  logic [ADDR_W-1:0] cell_addr;
  region_e           region_s0, s1_region, s2_region;
  logic              s1_valid, s1_hsync, s1_vsync, s1_fs;
  logic              s2_valid, s2_hsync, s2_vsync, s2_fs;
  logic [11:0]       colour;
  logic              unused_owner_hi;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .h_wrap    (h_wrap),
    .v_wrap    (v_wrap),
    .visible   (visible),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  assign h_next = h_wrap ? '0 : hcount + 1'b1;
  assign v_next = v_wrap ? '0 : vcount + 1'b1;

  // Trackers are loaded from the next raster position so they line up with hcount/vcount.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_x   <= '0;
      cell_x <= '0;
      px_y   <= '0;
      cell_y <= '0;
    end else begin
      if (h_next == HW'(ORG_X)) begin
        px_x   <= '0;
        cell_x <= '0;
      end else if (px_x == PW'(CELL - 1)) begin
        px_x   <= '0;
        cell_x <= cell_x + 1'b1;
      end else begin
        px_x <= px_x + 1'b1;
      end
      if (h_wrap) begin
        if (v_next == VW'(ORG_Y)) begin
          px_y   <= '0;
          cell_y <= '0;
        end else if (px_y == PW'(CELL - 1)) begin
          px_y   <= '0;
          cell_y <= cell_y + 1'b1;
        end else begin
          px_y <= px_y + 1'b1;
        end
      end
    end
  end

  assign in_board_x = (int'(hcount) >= ORG_X) && (int'(hcount) < X_END);
  assign in_board_y = (int'(vcount) >= ORG_Y) && (int'(vcount) < Y_END);
  assign on_grid    = (int'(px_x) < GRID) || (int'(px_y) < GRID);
  assign fs_s0      = (hcount == '0) && (vcount == '0);
  assign cell_addr  = ADDR_W'(cell_y) * ADDR_W'(BOARD_W) + ADDR_W'(cell_x);

  always_comb begin
    region_s0 = REG_BLANK;
    if (visible) begin
      if (in_board_x && in_board_y) begin
        region_s0 = on_grid ? REG_GRID : REG_CELL;
      end else if (int'(hcount) < ORG_X) begin
        region_s0 = REG_LEFT;
      end else if (int'(hcount) >= X_END) begin
        region_s0 = REG_RIGHT;
      end else begin
        region_s0 = REG_OUTER;
      end
    end
  end

`ifdef VGA_CURSOR_EN
  logic [5:0] frame_cnt;
  logic       frame_seen, cursor_s0, s1_cursor, s2_cursor;
  logic       ring_x, ring_y;

  assign ring_x    = (int'(px_x) >= GRID) && (int'(px_x) < 2 * GRID);
  assign ring_y    = (int'(px_y) >= GRID) && (int'(px_y) < 2 * GRID);
  assign cursor_s0 = (region_s0 == REG_CELL) && (int'(cell_x) == int'(cursor_x)) &&
                     (int'(cell_y) == int'(cursor_y)) && (ring_x || ring_y) && !frame_cnt[5];

  // frame_cnt holds the index of the frame on screen; the first pulse after reset is frame 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt  <= '0;
      frame_seen <= 1'b0;
      s1_cursor  <= 1'b0;
      s2_cursor  <= 1'b0;
    end else begin
      if (frame_start) begin
        frame_seen <= 1'b1;
        if (frame_seen) frame_cnt <= frame_cnt + 1'b1;
      end
      s1_cursor <= cursor_s0;
      s2_cursor <= s1_cursor;
    end
  end
`endif

  assign unused_owner_hi = ^vram.vram_q[CELL_BITS-1:3];

  always_comb begin
    colour = COL_BLANK;
    case (s2_region)
      REG_GRID:  colour = COL_GRID;
      REG_CELL:  colour = owner_colour(vram.vram_q[2:0]);
      REG_LEFT:  colour = COL_LEFT;
      REG_RIGHT: colour = COL_RIGHT;
      REG_OUTER: colour = COL_OUTER;
      default:   colour = COL_BLANK;
    endcase
`ifdef VGA_CURSOR_EN
    if (s2_cursor) colour = COL_CURSOR;
`endif
  end

  // Stage 1 issues the VRAM read, stage 2 meets vram_q, the output register closes the pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_region      <= REG_BLANK;
      s1_hsync       <= 1'b1;
      s1_vsync       <= 1'b1;
      s1_fs          <= 1'b0;
      vram.vram_addr <= '0;
      s2_valid       <= 1'b0;
      s2_region      <= REG_BLANK;
      s2_hsync       <= 1'b1;
      s2_vsync       <= 1'b1;
      s2_fs          <= 1'b0;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      rgb_out        <= '0;
      frame_start    <= 1'b0;
    end else begin
      s1_valid       <= 1'b1;
      s1_region      <= region_s0;
      s1_hsync       <= hsync_raw;
      s1_vsync       <= vsync_raw;
      s1_fs          <= fs_s0;
      vram.vram_addr <= (region_s0 == REG_CELL) ? cell_addr : '0;
      s2_valid       <= s1_valid;
      s2_region      <= s1_region;
      s2_hsync       <= s1_hsync;
      s2_vsync       <= s1_vsync;
      s2_fs          <= s1_fs;
      hsync          <= s2_valid ? s2_hsync : 1'b1;
      vsync          <= s2_valid ? s2_vsync : 1'b1;
      rgb_out        <= s2_valid ? colour : 12'h000;
      frame_start    <= s2_valid && s2_fs;
    end
  end

endmodule
